// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: FSM states, widths, codeword positions and parity.
// Data vectors are packed d1 in bit 0 through d4 in bit 3.
package hamming_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned PAR_W  = 3;
    localparam int unsigned CNT_W  = 3;

    // Codeword bit index = position - 1.
    localparam int unsigned POS_P1 = 0;
    localparam int unsigned POS_P2 = 1;
    localparam int unsigned POS_D1 = 2;
    localparam int unsigned POS_P4 = 3;
    localparam int unsigned POS_D2 = 4;
    localparam int unsigned POS_D3 = 5;
    localparam int unsigned POS_D4 = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ENCODE = 3'd2,
        SEND   = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Returns {p4, p2, p1} with even parity; the decoder reuses this for its syndrome.
    function automatic logic [PAR_W-1:0] hamming74_parity(input logic [DATA_W-1:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {p4, p2, p1};
    endfunction

endpackage

// File: rtl/hamming74_parity_gen.sv
// Combinational Hamming(7,4) codeword builder: 4 data bits to positions p1 p2 d1 p4 d2 d3 d4.
module hamming74_parity_gen
    import hamming_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_c
);

    logic [PAR_W-1:0] par_c;

    always_comb begin
        par_c          = hamming74_parity(data_i) ^ {PAR_W{ODD_PARITY}};
        code_c         = '0;
        code_c[POS_P1] = par_c[0];
        code_c[POS_P2] = par_c[1];
        code_c[POS_D1] = data_i[0];
        code_c[POS_P4] = par_c[2];
        code_c[POS_D2] = data_i[1];
        code_c[POS_D3] = data_i[2];
        code_c[POS_D4] = data_i[3];
    end

endmodule

// File: rtl/hamming74_serial_encoder.sv
// Serial Hamming(7,4) transmitter: shifts in 4 data bits, encodes, then streams
// the 7-bit codeword under tx_ready backpressure. Outputs are registered from next state.
module hamming74_serial_encoder
    import hamming_pkg::*;
#(
    parameter bit POS1_FIRST = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic clk,
    input  logic counter_reset_n,
    input  logic start,
    input  logic data_in,
    input  logic tx_ready,
    output logic ready,
    output logic shift,
    output logic tx_valid,
    output logic tx_bit,
    output logic done
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   code_c;
    logic [CNT_W-1:0]    tx_idx_c;
    logic                ready_q, shift_q, tx_valid_q, tx_bit_q, done_q;
    logic                ready_d, shift_d, tx_valid_d, tx_bit_d, done_d;

    hamming74_parity_gen #(
        .ODD_PARITY (ODD_PARITY)
    ) u_parity_gen (
        .data_i (data_q),
        .code_c (code_c)
    );

    // Next-state logic; each input is only looked at in the state that owns it.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                data_d[count_q[1:0]] = data_in;
                if (count_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ENCODE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ENCODE: begin
                code_d  = code_c;
                state_d = SEND;
                count_d = '0;
            end
            SEND: begin
                if (tx_ready) begin
                    if (count_q == CNT_W'(CODE_W - 1)) begin
                        state_d = DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Output decode from next state so the ports come straight from flops.
    always_comb begin
        tx_idx_c   = POS1_FIRST ? count_d : (CNT_W'(CODE_W - 1) - count_d);
        ready_d    = (state_d == IDLE);
        shift_d    = (state_d == LOAD);
        tx_valid_d = (state_d == SEND);
        done_d     = (state_d == DONE);
        tx_bit_d   = (state_d == SEND) ? code_d[tx_idx_c] : 1'b0;
    end

    always_ff @(posedge clk or negedge counter_reset_n) begin
        if (!counter_reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            data_q     <= '0;
            code_q     <= '0;
            ready_q    <= 1'b1;
            shift_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_bit_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            data_q     <= data_d;
            code_q     <= code_d;
            ready_q    <= ready_d;
            shift_q    <= shift_d;
            tx_valid_q <= tx_valid_d;
            tx_bit_q   <= tx_bit_d;
            done_q     <= done_d;
        end
    end

    assign ready    = ready_q;
    assign shift    = shift_q;
    assign tx_valid = tx_valid_q;
    assign tx_bit   = tx_bit_q;
    assign done     = done_q;

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Bench for hamming74_serial_encoder: three parameterisations run in lockstep on
// shared stimulus; a scoreboard holds each word's expected streams until done.
module tb_hamming74_serial_encoder;

    // Streams are written first-transmitted bit in bit 6.
    typedef struct packed {
        logic [6:0] a;   // POS1_FIRST=1, even
        logic [6:0] b;   // POS1_FIRST=0, even
        logic [6:0] c;   // POS1_FIRST=1, odd
    } exp_t;

    typedef struct {
        logic [3:0] d;   // {d4,d3,d2,d1}
        exp_t       e;
    } vec_t;

    logic clk;
    logic counter_reset_n;
    logic start, data_in, tx_ready;
    logic ready_a, shift_a, tx_valid_a, tx_bit_a, done_a;
    logic ready_b, shift_b, tx_valid_b, tx_bit_b, done_b;
    logic ready_c, shift_c, tx_valid_c, tx_bit_c, done_c;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    logic [6:0] got_a, got_b, got_c;
    int         nb_a, nb_b, nb_c;
    logic       prev_stall, stall_bit;

    hamming74_serial_encoder u_dut_a (
        .clk(clk), .counter_reset_n(counter_reset_n), .start(start), .data_in(data_in),
        .tx_ready(tx_ready), .ready(ready_a), .shift(shift_a), .tx_valid(tx_valid_a),
        .tx_bit(tx_bit_a), .done(done_a)
    );

    hamming74_serial_encoder #(.POS1_FIRST(1'b0)) u_dut_b (
        .clk(clk), .counter_reset_n(counter_reset_n), .start(start), .data_in(data_in),
        .tx_ready(tx_ready), .ready(ready_b), .shift(shift_b), .tx_valid(tx_valid_b),
        .tx_bit(tx_bit_b), .done(done_b)
    );

    hamming74_serial_encoder #(.ODD_PARITY(1'b1)) u_dut_c (
        .clk(clk), .counter_reset_n(counter_reset_n), .start(start), .data_in(data_in),
        .tx_ready(tx_ready), .ready(ready_c), .shift(shift_c), .tx_valid(tx_valid_c),
        .tx_bit(tx_bit_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference built from the position-index definition of Hamming parity.
    function automatic logic [6:0] ref_stream(input logic [3:0] d, input bit pos1, input bit odd);
        logic [7:0] cw;
        logic [6:0] s;
        logic       p;
        int         dpos[4];
        dpos = '{3, 5, 6, 7};
        cw   = '0;
        for (int i = 0; i < 4; i++) cw[3'(dpos[i])] = d[2'(i)];
        for (int j = 0; j < 3; j++) begin
            p = odd;
            for (int pos = 1; pos < 8; pos++)
                if (pos != (1 << j) && ((pos >> j) & 1) == 1) p ^= cw[3'(pos)];
            cw[3'(1 << j)] = p;
        end
        for (int k = 0; k < 7; k++) s[3'(6 - k)] = pos1 ? cw[3'(k + 1)] : cw[3'(7 - k)];
        return s;
    endfunction

    function automatic exp_t ref_exp(input logic [3:0] d);
        exp_t e;
        e.a = ref_stream(d, 1'b1, 1'b0);
        e.b = ref_stream(d, 1'b0, 1'b0);
        e.c = ref_stream(d, 1'b1, 1'b1);
        return e;
    endfunction

    // Monitor: collect accepted bits, check stall hold, score on done.
    always @(negedge clk) begin
        #2;
        if (!counter_reset_n) begin
            got_a = '0; got_b = '0; got_c = '0;
            nb_a = 0; nb_b = 0; nb_c = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && tx_valid_a) chk("stall_hold", 32'(tx_bit_a), 32'(stall_bit));
            prev_stall = tx_valid_a && !tx_ready;
            stall_bit  = tx_bit_a;
            if (tx_valid_a && tx_ready) begin got_a = {got_a[5:0], tx_bit_a}; nb_a++; end
            if (tx_valid_b && tx_ready) begin got_b = {got_b[5:0], tx_bit_b}; nb_b++; end
            if (tx_valid_c && tx_ready) begin got_c = {got_c[5:0], tx_bit_c}; nb_c++; end
            if (done_a) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done actual=1 required=0 at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("stream_pos1_even", 32'(got_a), 32'(e.a));
                    chk("stream_pos7_even", 32'(got_b), 32'(e.b));
                    chk("stream_pos1_odd",  32'(got_c), 32'(e.c));
                    chk("bit_count", 32'(nb_a), 32'd7);
                    chk("done_lockstep", 32'({done_b, done_c}), 32'b11);
                end
                got_a = '0; got_b = '0; got_c = '0;
                nb_a = 0; nb_b = 0; nb_c = 0;
            end
        end
    end

    // Drive one word from an IDLE negedge; returns at the following IDLE negedge.
    task automatic run_word(input logic [3:0] d, input exp_t e, input int stall_at,
                            input int stall_len, input bit keep_start, input bit noise,
                            input int abort_at);
        int cyc, nshift, nacc, nstall, fv, done_cyc;
        cyc = 0; nshift = 0; nacc = 0; nstall = 0; fv = -1; done_cyc = -1;
        chk("ready_before_start", 32'(ready_a), 32'd1);
        start    = 1'b1;
        data_in  = 1'b0;
        tx_ready = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        while (done_cyc < 0 && cyc < 60) begin
            cyc++;
            start = noise ? 1'($urandom_range(0, 1)) : keep_start;
            if (cyc == 1) begin
                chk("shift_latency", 32'(shift_a), 32'd1);
                chk("ready_drop", 32'(ready_a), 32'd0);
            end
            if (shift_a) begin
                data_in = d[2'(nshift)];
                nshift++;
            end else begin
                data_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (tx_valid_a) begin
                if (fv < 0) fv = cyc;
                if (nacc == abort_at) begin
                    counter_reset_n = 1'b0;
                    start = 1'b0;
                    #1;
                    chk("abort_ready", 32'(ready_a), 32'd1);
                    chk("abort_outs", 32'({shift_a, tx_valid_a, tx_bit_a, done_a}), 32'd0);
                    chk("abort_valid_bc", 32'({tx_valid_b, tx_valid_c}), 32'd0);
                    void'(sb.pop_back());
                    repeat (2) begin
                        @(negedge clk);
                        chk("abort_no_done", 32'(done_a), 32'd0);
                    end
                    counter_reset_n = 1'b1;
                    @(negedge clk);
                    chk("abort_idle", 32'(ready_a), 32'd1);
                    return;
                end
                tx_ready = (nacc == stall_at && nstall < stall_len) ? 1'b0 : 1'b1;
                if (tx_ready) nacc++;
                else nstall++;
            end else begin
                tx_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done_a) done_cyc = cyc;
            @(negedge clk);
        end
        start = keep_start;
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("shift_cycles", 32'(nshift), 32'd4);
        chk("first_valid_lat", 32'(fv), 32'd6);
        chk("done_lat", 32'(done_cyc), 32'(13 + stall_len));
        chk("done_one_cycle", 32'(done_a), 32'd0);
        chk("ready_after_done", 32'(ready_a), 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{d: 4'b1101, e: '{a: 7'b0110011, b: 7'b1100110, c: 7'b1011011}};
        vecs[1] = '{d: 4'b0000, e: '{a: 7'b0000000, b: 7'b0000000, c: 7'b1101000}};
        vecs[2] = '{d: 4'b1111, e: '{a: 7'b1111111, b: 7'b1111111, c: 7'b0010111}};
        vecs[3] = '{d: 4'b0011, e: '{a: 7'b0111100, b: 7'b0011110, c: 7'b1010100}};
        vecs[4] = '{d: 4'b0010, e: '{a: 7'b1001100, b: 7'b0011001, c: 7'b0100100}};
        vecs[5] = '{d: 4'b1000, e: '{a: 7'b1101001, b: 7'b1001011, c: 7'b0000001}};

        counter_reset_n = 1'b0;
        start = 1'b0; data_in = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_shift", 32'(shift_a), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid_a), 32'd0);
        chk("rst_tx_bit", 32'(tx_bit_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        counter_reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", 32'({ready_a, shift_a, tx_valid_a}), 32'b100);

        for (int i = 0; i < 6; i++) run_word(vecs[i].d, vecs[i].e, 99, 0, 1'b0, 1'b0, -1);

        // Stall three cycles after the second accepted bit.
        run_word(4'b1101, vecs[0].e, 2, 3, 1'b0, 1'b0, -1);

        // Back-to-back words with start held high.
        run_word(4'b0000, vecs[1].e, 99, 0, 1'b1, 1'b0, -1);
        run_word(4'b1111, vecs[2].e, 99, 0, 1'b0, 1'b0, -1);

        // Reset while bit 4 is on the line, then a clean word.
        run_word(4'b1101, vecs[0].e, 99, 0, 1'b0, 1'b0, 3);
        run_word(4'b0011, vecs[3].e, 99, 0, 1'b0, 1'b0, -1);

        // Random regression with start/data_in/tx_ready noise outside their states.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            run_word(d, ref_exp(d), int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                     1'b0, 1'b1, -1);
        end

        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_end", 32'({ready_a, tx_valid_a, done_a}), 32'b100);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
